// File: rtl/r16_fft_pkg.sv
// Shared constants for the radix-16 65536-point FFT: sequencer state encoding and phase lengths.
// Used by the sequencer, the AGU and the BFU datapath.
package r16_fft_pkg;

    localparam int unsigned CNT_W      = 15;
    localparam int unsigned LOAD_CYC   = 4097;
    localparam int unsigned COMP_CYC   = 16432;
    localparam int unsigned DRAIN_CYC  = 48;
    localparam int unsigned UNLOAD_CYC = 4096;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_COMP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StLoad   = ST_LOAD,
        StComp   = ST_COMP,
        StDrain  = ST_DRAIN,
        StUnload = ST_UNLOAD,
        StDone   = ST_DONE
    } seq_state_e;

endpackage

// File: rtl/r16_phase_cnt.sv
// Phase cycle counter: synchronous clear (priority over enable) and a terminal-value flag.
module r16_phase_cnt #(
    parameter int unsigned CntW = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [CntW-1:0] term_i,
    output logic [CntW-1:0] cnt_o,
    output logic            tc_o
);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/r16_fft_seq_ctrl.sv
// Top-level LOAD/COMPUTE/DRAIN/UNLOAD sequencer driving the radix-16 FFT AGU strobes.
// Define R16_SEQ_PERF_EN to add the perf_cyc_o / hold_cyc_o run counters.
module r16_fft_seq_ctrl
    import r16_fft_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             hold_i,
    output logic             agu_en_o,
    output logic             rc_sel_o,
    output logic             wrfd_en_o,
    output logic             fft_fin_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dirty_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] phase_cnt_o
`ifdef R16_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cyc_o,
    output logic [31:0]      hold_cyc_o
`endif
);

    seq_state_e       state_q, state_d;
    logic             dirty_q, dirty_d;
    logic             agu_en_q, agu_en_d, rc_sel_q, rc_sel_d;
    logic             wrfd_en_q, wrfd_en_d, fft_fin_q, fft_fin_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             counting, stall, cnt_en, cnt_clr, cnt_tc;
    logic [CNT_W-1:0] cnt_term;

    r16_phase_cnt #(
        .CntW (CNT_W)
    ) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .cnt_o  (phase_cnt_o),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        dirty_d  = dirty_q;
        counting = (state_q == StLoad) || (state_q == StComp) || (state_q == StUnload);
        stall    = counting && hold_i;

        case (state_q)
            StLoad:   cnt_term = CNT_W'(LOAD_CYC - 1);
            StComp:   cnt_term = CNT_W'(COMP_CYC - 1);
            StDrain:  cnt_term = CNT_W'(DRAIN_CYC - 1);
            StUnload: cnt_term = CNT_W'(UNLOAD_CYC - 1);
            default:  cnt_term = '0;
        endcase

        // Abort beats hold and terminal count; leaving mid-count strands the AGU counter.
        if (abort_i && (state_q != StIdle) && (state_q != StDone)) begin
            state_d = StIdle;
            if (counting) begin
                dirty_d = 1'b1;
            end
        end else begin
            case (state_q)
                StIdle:   if (start_i && !dirty_q) state_d = StLoad;
                StLoad:   if (!hold_i && cnt_tc) state_d = StComp;
                StComp:   if (!hold_i && cnt_tc) state_d = StDrain;
                StDrain:  if (cnt_tc) state_d = StUnload;
                StUnload: if (!hold_i && cnt_tc) state_d = StDone;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end

        // The drain pipeline free-runs, so hold only freezes the counting phases.
        cnt_en  = (counting && !hold_i) || (state_q == StDrain);
        cnt_clr = (state_d != state_q);

        agu_en_d  = ((state_d == StLoad) || (state_d == StComp)) && !stall;
        rc_sel_d  = (state_d == StLoad);
        wrfd_en_d = (state_d == StUnload) && !stall;
        fft_fin_d = (state_d == StUnload);
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dirty_q   <= 1'b0;
            agu_en_q  <= 1'b0;
            rc_sel_q  <= 1'b0;
            wrfd_en_q <= 1'b0;
            fft_fin_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dirty_q   <= dirty_d;
            agu_en_q  <= agu_en_d;
            rc_sel_q  <= rc_sel_d;
            wrfd_en_q <= wrfd_en_d;
            fft_fin_q <= fft_fin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign state_o   = state_q;
    assign dirty_o   = dirty_q;
    assign agu_en_o  = agu_en_q;
    assign rc_sel_o  = rc_sel_q;
    assign wrfd_en_o = wrfd_en_q;
    assign fft_fin_o = fft_fin_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

`ifdef R16_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d, hold_cyc_q, hold_cyc_d;

    // Counting over every non-IDLE edge, including DONE, yields start-edge-to-done latency.
    always_comb begin
        perf_d     = perf_q;
        hold_cyc_d = hold_cyc_q;
        if ((state_q == StIdle) && (state_d == StLoad)) begin
            perf_d     = '0;
            hold_cyc_d = '0;
        end else begin
            if ((state_q != StIdle) && (perf_q != '1)) begin
                perf_d = perf_q + 32'd1;
            end
            if (stall && (hold_cyc_q != '1)) begin
                hold_cyc_d = hold_cyc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q     <= '0;
            hold_cyc_q <= '0;
        end else begin
            perf_q     <= perf_d;
            hold_cyc_q <= hold_cyc_d;
        end
    end

    assign perf_cyc_o = perf_q;
    assign hold_cyc_o = hold_cyc_q;
`endif

endmodule
